// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants and helpers for the memory responder block:
//               FSM state encodings, error response word, alignment mask and
//               word-index width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // FSM state encodings (IDLE, WAIT, RESP)
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // Data returned on ReadData for an illegal access
    localparam logic [31:0] c_err_word_default = 32'hDEAD_BEEF;

    // Low address bits required for a word-aligned access
    localparam logic [1:0] c_align_ok = 2'b00;

    // Bits needed to index a word array of the given depth (at least 1)
    function automatic int idx_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : DEPTH_WORDS x 32 storage. Synchronous write, combinational
//               read. Not reset: contents are undefined until written.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [AW-1:0] i_raddr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Store a word on the rising edge when a write is committed
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed unified instruction/data memory with a fixed
//               response latency. Captures one request in IDLE, waits, then
//               commits the access and strobes MemReady for one cycle.
//               Misaligned or out-of-range accesses answer with MemErr and
//               ERR_WORD and leave the array untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] ERR_WORD    = c_err_word_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int         c_aw       = idx_width(DEPTH_WORDS);
    localparam logic [2:0] c_cnt_load = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
    localparam logic       c_single   = (LATENCY == 1);

    logic [1:0]      r_state;
    logic [2:0]      r_cnt;
    logic            r_write;
    logic            r_err;
    logic [c_aw-1:0] r_idx;
    logic [31:0]     r_wdata;

    logic            w_live_err;
    logic            w_capture;
    logic            w_commit;
    logic            w_c_write;
    logic            w_c_err;
    logic [c_aw-1:0] w_c_idx;
    logic [31:0]     w_c_wdata;
    logic            w_array_we;
    logic [31:0]     w_rdata;

    assign w_live_err = (Adr[1:0] != c_align_ok) ||
                        ({2'b00, Adr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_capture  = (r_state == c_st_idle) && MemReq;

    // With LATENCY=1 the commit happens on the capture edge itself, so the
    // live request is used; otherwise the latched copy is committed.
    assign w_commit   = ((r_state == c_st_wait) && (r_cnt == 3'd0)) ||
                        (c_single && w_capture);

    // Select live or latched request fields for the commit edge
    always_comb begin
        w_c_write = r_write;
        w_c_err   = r_err;
        w_c_idx   = r_idx;
        w_c_wdata = r_wdata;
        if (r_state == c_st_idle) begin
            w_c_write = MemWrite;
            w_c_err   = w_live_err;
            w_c_idx   = Adr[c_aw+1:2];
            w_c_wdata = WriteData;
        end
    end

    assign w_array_we = w_commit && w_c_write && !w_c_err;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_aw)
    ) u_array (
        .clk     (clk),
        .i_we    (w_array_we),
        .i_waddr (w_c_idx),
        .i_raddr (w_c_idx),
        .i_wdata (w_c_wdata),
        .o_rdata (w_rdata)
    );

    // Request capture, wait countdown and state sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 3'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (MemReq) begin
                        r_write <= MemWrite;
                        r_err   <= w_live_err;
                        r_idx   <= Adr[c_aw+1:2];
                        r_wdata <= WriteData;
                        if (c_single) begin
                            r_state <= c_st_resp;
                        end else begin
                            r_cnt   <= c_cnt_load;
                            r_state <= c_st_wait;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Response registers: load on the commit edge, drop the strobe after RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadData <= 32'd0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
        end else if (w_commit) begin
            MemReady <= 1'b1;
            MemErr   <= w_c_err;
            if (w_c_err) begin
                ReadData <= ERR_WORD;
            end else if (w_c_write) begin
                ReadData <= w_c_wdata;
            end else begin
                ReadData <= w_rdata;
            end
        end else if (r_state == c_st_resp) begin
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Three instances with
//               LATENCY 1, 2 and 7 run the same directed vectors side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [3];
    logic        wr  [3];
    logic [31:0] adr [3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic        rdy [3];
    logic        er  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mem_responder #(
                .DEPTH_WORDS (64),
                .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 2 : 7)),
                .ERR_WORD    (32'hDEAD_BEEF)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .MemReq    (req[g]),
                .MemWrite  (wr[g]),
                .Adr       (adr[g]),
                .WriteData (wd[g]),
                .ReadData  (rd[g]),
                .MemReady  (rdy[g]),
                .MemErr    (er[g])
            );
        end
    endgenerate

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        scr;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] exp3 [3];

    // One access on all three instances; MemReady must pulse exactly once,
    // LATENCY-1 edges after the capture edge (capture edge = offset 0).
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic scr,
                          input logic [31:0] exp_d [3], input logic exp_e);
        int          seen [3];
        int          off  [3];
        logic [31:0] dat  [3];
        logic        e    [3];
        for (int i = 0; i < 3; i++) begin
            seen[i] = 0; off[i] = -1; dat[i] = 32'd0; e[i] = 1'b0;
            req[i] = 1'b1; wr[i] = w; adr[i] = a; wd[i] = d;
        end
        for (int o = 0; o < 10; o++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rdy[i]) begin
                    seen[i]++; off[i] = o; dat[i] = rd[i]; e[i] = er[i];
                end
                if (o == 0) begin
                    req[i] = 1'b0;
                    if (scr) begin
                        adr[i] = a + 32'd4;
                        wd[i]  = 32'd0;
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s L%0d pulses", tag, lat(i)), seen[i], 32'd1);
            check($sformatf("%s L%0d offset", tag, lat(i)), off[i], lat(i) - 1);
            check($sformatf("%s L%0d data", tag, lat(i)), dat[i], exp_d[i]);
            check($sformatf("%s L%0d err", tag, lat(i)), {31'd0, e[i]}, {31'd0, exp_e});
        end
    endtask

    initial begin
        int          np   [3];
        logic        prev [3];
        logic [31:0] b2b_exp [3];

        //            w     adr            wdata          scr   exp data       err
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0000, 32'h1111_0000, 1'b0, 32'h1111_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0004, 32'h2222_0004, 1'b0, 32'h2222_0004, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'h3333_0008, 1'b0, 32'h3333_0008, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0024, 32'h2424_2424, 1'b0, 32'h2424_2424, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0020, 32'hAAAA_5555, 1'b1, 32'hAAAA_5555, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'hAAAA_5555, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 1'b0, 32'h2424_2424, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[15] = '{1'b1, 32'h8000_0000, 32'h0000_0055, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[16] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_0000, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset L%0d ReadData", lat(i)), rd[i], 32'd0);
            check($sformatf("reset L%0d MemReady", lat(i)), {31'd0, rdy[i]}, 32'd0);
            check($sformatf("reset L%0d MemErr", lat(i)), {31'd0, er[i]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single accesses
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < 3; i++) exp3[i] = vecs[k].exp_d;
            access($sformatf("vec%0d", k), vecs[k].w, vecs[k].a, vecs[k].d,
                   vecs[k].scr, exp3, vecs[k].exp_e);
        end

        // MemReq held high across reads of 0x0, 0x4, 0x8: pulses every
        // LATENCY+1 cycles, never on consecutive cycles.
        b2b_exp[0] = 32'h1111_0000;
        b2b_exp[1] = 32'h2222_0004;
        b2b_exp[2] = 32'h3333_0008;
        for (int i = 0; i < 3; i++) begin
            np[i] = 0; prev[i] = 1'b0;
            req[i] = 1'b1; wr[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0;
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rdy[i]) begin
                    if (np[i] < 3) begin
                        check($sformatf("b2b L%0d pulse%0d cycle", lat(i), np[i]), c,
                              (lat(i) - 1) + np[i] * (lat(i) + 1));
                        check($sformatf("b2b L%0d pulse%0d data", lat(i), np[i]), rd[i],
                              b2b_exp[np[i]]);
                        check($sformatf("b2b L%0d pulse%0d back-to-back", lat(i), np[i]),
                              {31'd0, prev[i]}, 32'd0);
                    end
                    np[i]++;
                    if (np[i] < 3) adr[i] = 32'(np[i] * 4);
                    else           req[i] = 1'b0;
                end
                prev[i] = rdy[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b L%0d pulse count", lat(i)), np[i], 32'd3);
        end

        // Reset asserted between edges right after capturing a write to 0x20.
        // Only the LATENCY=1 instance has already committed it.
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; wr[i] = 1'b1; adr[i] = 32'h20; wd[i] = 32'h0BAD_0BAD;
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset L%0d ReadData", lat(i)), rd[i], 32'd0);
            check($sformatf("midreset L%0d MemReady", lat(i)), {31'd0, rdy[i]}, 32'd0);
            check($sformatf("midreset L%0d MemErr", lat(i)), {31'd0, er[i]}, 32'd0);
            req[i] = 1'b0; wr[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp3[0] = 32'h0BAD_0BAD;
        exp3[1] = 32'hAAAA_5555;
        exp3[2] = 32'hAAAA_5555;
        access("after reset", 1'b0, 32'h20, 32'd0, 1'b0, exp3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
